// File: rtl/mem_seq_pkg.sv
// Shared definitions for the memory-access sequencer: MEM command codes,
// FSM state encoding and default widths.
package mem_seq_pkg;

   localparam int ADDR_W_DEF = 9;
   localparam int DATA_W_DEF = 16;

   // MNONE must be driven whenever idle: MREAD turns on MEM's output drive.
   localparam logic [1:0] MREAD  = 2'b00;
   localparam logic [1:0] MWRITE = 2'b01;
   localparam logic [1:0] MNONE  = 2'b10;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      F_ADDR = 3'd1,
      F_CAP  = 3'd2,
      L_ADDR = 3'd3,
      L_CAP  = 3'd4,
      STORE  = 3'd5
   } state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter: synchronous reset, parallel load and wrapping increment.
// Load wins over increment; the sequencer never asserts both together.
module pc_reg #(
   parameter int                ADDR_W   = 9,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_val,
   input  logic              inc,
   output logic [ADDR_W-1:0] pc
);

   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= load_val;
      end else if (inc) begin
         pc <= pc + ADDR_W'(1);
      end
   end

endmodule

// File: rtl/mem_sequencer.sv
// Serialises instruction fetches, loads and stores onto the single MEM port
// and hides the one-cycle synchronous RAM read latency behind req/done.
module mem_sequencer
   import mem_seq_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                DATA_W   = DATA_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_req,
   input  logic              ls_req,
   input  logic              ls_write,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic [DATA_W-1:0] mem_data_in,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [1:0]        mem_cmd,
   output logic [DATA_W-1:0] write_data,
   output logic [ADDR_W-1:0] pc_out,
   output logic [DATA_W-1:0] ir_out,
   output logic [DATA_W-1:0] rdata_out,
   output logic              busy,
   output logic              fetch_done,
   output logic              ls_done
);

   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              pc_ld;
   logic              pc_inc;

   // A branch target loaded alongside a fetch request is the address fetched.
   assign pc_ld  = (state == IDLE) && pc_load;
   assign pc_inc = (state == F_CAP);

   pc_reg #(
      .ADDR_W  (ADDR_W),
      .RESET_PC(RESET_PC)
   ) u_pc (
      .clk     (clk),
      .reset   (reset),
      .load    (pc_ld),
      .load_val(pc_in),
      .inc     (pc_inc),
      .pc      (pc_out)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         ir_out     <= '0;
         rdata_out  <= '0;
         fetch_done <= 1'b0;
         ls_done    <= 1'b0;
      end else begin
         fetch_done <= 1'b0;
         ls_done    <= 1'b0;
         case (state)
            IDLE: begin
               if (ls_req) begin
                  state <= ls_write ? STORE : L_ADDR;
               end else if (fetch_req) begin
                  state <= F_ADDR;
               end
            end
            F_ADDR: state <= F_CAP;
            F_CAP: begin
               // RAM is only selected when the top address bit is clear.
               ir_out     <= pc_out[ADDR_W-1] ? '0 : mem_data_in;
               fetch_done <= 1'b1;
               state      <= IDLE;
            end
            L_ADDR: state <= L_CAP;
            L_CAP: begin
               rdata_out <= addr_q[ADDR_W-1] ? '0 : mem_data_in;
               ls_done   <= 1'b1;
               state     <= IDLE;
            end
            STORE: begin
               ls_done <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Operand capture needs no reset: it is only observed after a request.
   always_ff @(posedge clk) begin
      if (state == IDLE && ls_req) begin
         addr_q  <= ls_addr;
         wdata_q <= ls_wdata;
      end
   end

   assign busy = (state != IDLE);

   always_comb begin
      mem_cmd    = MNONE;
      mem_addr   = pc_out;
      write_data = '0;
      case (state)
         F_ADDR, F_CAP: mem_cmd = MREAD;
         L_ADDR, L_CAP: begin
            mem_cmd  = MREAD;
            mem_addr = addr_q;
         end
         STORE: begin
            mem_cmd    = MWRITE;
            mem_addr   = addr_q;
            write_data = wdata_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer with a 256-word synchronous RAM model
// selected when address bit 8 is clear.
module tb_mem_sequencer;
   import mem_seq_pkg::*;

   localparam logic [1:0] OP_F = 2'd0;
   localparam logic [1:0] OP_L = 2'd1;
   localparam logic [1:0] OP_S = 2'd2;

   typedef struct {
      logic [1:0]  op;
      logic [8:0]  addr;
      logic [15:0] wdata;
      logic        pcl;
      logic [8:0]  pcin;
      logic [15:0] exp_data;
      logic [8:0]  exp_pc;
      int          lat;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset, fetch_req, ls_req, ls_write, pc_load, preload, mon_en;
   logic [8:0]  ls_addr, pc_in, mem_addr, pc_out;
   logic [15:0] ls_wdata, mem_data_in, write_data, ir_out, rdata_out;
   logic [1:0]  mem_cmd;
   logic        busy, fetch_done, ls_done;
   logic [15:0] ram [256];
   logic [15:0] dout;
   int          errors = 0;
   int          checks = 0;
   vec_t        vecs [12];

   always #5 clk = ~clk;

   mem_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .fetch_req  (fetch_req),
      .ls_req     (ls_req),
      .ls_write   (ls_write),
      .ls_addr    (ls_addr),
      .ls_wdata   (ls_wdata),
      .pc_load    (pc_load),
      .pc_in      (pc_in),
      .mem_data_in(mem_data_in),
      .mem_addr   (mem_addr),
      .mem_cmd    (mem_cmd),
      .write_data (write_data),
      .pc_out     (pc_out),
      .ir_out     (ir_out),
      .rdata_out  (rdata_out),
      .busy       (busy),
      .fetch_done (fetch_done),
      .ls_done    (ls_done)
   );

   // Unselected space returns junk so the sequencer's zero-forcing is visible.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) ram[i] <= 16'h0000;
         ram[8'h00] <= 16'hA5C3;
         ram[8'h01] <= 16'h1234;
         ram[8'hFF] <= 16'h0FF0;
         ram[8'hAB] <= 16'h5A5A;
      end else if (mem_cmd == MWRITE && !mem_addr[8]) begin
         ram[mem_addr[7:0]] <= write_data;
      end
      if (mem_cmd == MREAD) dout <= mem_addr[8] ? 16'hDEAD : ram[mem_addr[7:0]];
   end
   assign mem_data_in = dout;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (mem_cmd != MWRITE) check("wdata_zero_when_not_write", 32'(write_data), 32'h0);
         if (!busy) check("mnone_when_idle", 32'(mem_cmd), 32'(MNONE));
      end
   end

   task automatic wait_pulse(input bit is_ls, output int n);
      n = -1;
      for (int i = 1; i <= 12 && n < 0; i++) begin
         @(negedge clk);
         if (is_ls ? ls_done : fetch_done) n = i;
      end
   endtask

   task automatic do_op(input vec_t v, input int idx);
      int n;
      string tag;
      tag = $sformatf("vec%0d", idx);
      @(negedge clk);
      fetch_req = (v.op == OP_F);
      ls_req    = (v.op != OP_F);
      ls_write  = (v.op == OP_S);
      ls_addr   = v.addr;
      ls_wdata  = v.wdata;
      pc_load   = v.pcl;
      pc_in     = v.pcin;
      n = -1;
      for (int i = 1; i <= 12 && n < 0; i++) begin
         @(negedge clk);
         pc_load = 1'b0;
         if (i == 1) begin
            check({tag, "_cmd"}, 32'(mem_cmd), 32'((v.op == OP_S) ? MWRITE : MREAD));
            check({tag, "_addr"}, 32'(mem_addr), 32'(v.addr));
            if (v.op == OP_S) check({tag, "_wdata"}, 32'(write_data), 32'(v.wdata));
         end
         if (v.op == OP_F ? fetch_done : ls_done) n = i;
      end
      fetch_req = 1'b0;
      ls_req    = 1'b0;
      ls_write  = 1'b0;
      check({tag, "_latency"}, n, v.lat);
      check({tag, "_busy_at_done"}, 32'(busy), 32'h0);
      if (v.op == OP_F) check({tag, "_ir"}, 32'(ir_out), 32'(v.exp_data));
      if (v.op == OP_L) check({tag, "_rdata"}, 32'(rdata_out), 32'(v.exp_data));
      check({tag, "_pc"}, 32'(pc_out), 32'(v.exp_pc));
   endtask

   initial begin
      int n;
      vecs[0]  = '{OP_F, 9'h000, 16'h0000, 1'b0, 9'h000, 16'hA5C3, 9'h001, 3};
      vecs[1]  = '{OP_F, 9'h001, 16'h0000, 1'b0, 9'h000, 16'h1234, 9'h002, 3};
      vecs[2]  = '{OP_S, 9'h010, 16'hBEEF, 1'b0, 9'h000, 16'h0000, 9'h002, 2};
      vecs[3]  = '{OP_L, 9'h010, 16'h0000, 1'b0, 9'h000, 16'hBEEF, 9'h002, 3};
      vecs[4]  = '{OP_F, 9'h0FF, 16'h0000, 1'b1, 9'h0FF, 16'h0FF0, 9'h100, 3};
      vecs[5]  = '{OP_F, 9'h100, 16'h0000, 1'b0, 9'h000, 16'h0000, 9'h101, 3};
      vecs[6]  = '{OP_F, 9'h1FF, 16'h0000, 1'b1, 9'h1FF, 16'h0000, 9'h000, 3};
      vecs[7]  = '{OP_S, 9'h1AB, 16'h7777, 1'b0, 9'h000, 16'h0000, 9'h000, 2};
      vecs[8]  = '{OP_L, 9'h1AB, 16'h0000, 1'b0, 9'h000, 16'h0000, 9'h000, 3};
      vecs[9]  = '{OP_L, 9'h0AB, 16'h0000, 1'b0, 9'h000, 16'h5A5A, 9'h000, 3};
      vecs[10] = '{OP_F, 9'h000, 16'h0000, 1'b0, 9'h000, 16'hA5C3, 9'h001, 3};
      vecs[11] = '{OP_S, 9'h011, 16'hC0DE, 1'b0, 9'h000, 16'h0000, 9'h001, 2};

      reset = 1'b1; preload = 1'b1; mon_en = 1'b0;
      fetch_req = 0; ls_req = 0; ls_write = 0; pc_load = 0;
      ls_addr = '0; ls_wdata = '0; pc_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0; preload = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;
      check("rst_mem_cmd", 32'(mem_cmd), 32'(MNONE));
      check("rst_mem_addr", 32'(mem_addr), 32'h0);
      check("rst_pc", 32'(pc_out), 32'h0);
      check("rst_ir", 32'(ir_out), 32'h0);
      check("rst_rdata", 32'(rdata_out), 32'h0);
      check("rst_flags", {busy, fetch_done, ls_done}, 32'h0);

      for (int i = 0; i < 12; i++) do_op(vecs[i], i);

      // Load and fetch together: load first, pc_load while busy ignored,
      // then the still-held fetch is accepted in the load's done cycle.
      @(negedge clk);
      ls_req = 1; ls_write = 0; ls_addr = 9'h010; fetch_req = 1;
      @(negedge clk);
      check("prio_first_addr", 32'(mem_addr), 32'h010);
      pc_load = 1; pc_in = 9'h055;
      wait_pulse(1'b1, n);
      pc_load = 0; ls_req = 0;
      check("prio_ls_latency", n, 2);
      check("prio_rdata", 32'(rdata_out), 32'hBEEF);
      check("prio_no_fetch_done", 32'(fetch_done), 32'h0);
      check("busy_pcload_ignored", 32'(pc_out), 32'h001);
      wait_pulse(1'b0, n);
      fetch_req = 0;
      check("b2b_fetch_latency", n, 3);
      check("b2b_ir", 32'(ir_out), 32'h1234);
      check("b2b_pc", 32'(pc_out), 32'h002);

      // Reset asserted during F_CAP drops the fetch without a done pulse.
      @(negedge clk);
      fetch_req = 1;
      @(negedge clk);
      @(negedge clk);
      check("midrst_fcap_cmd", 32'(mem_cmd), 32'(MREAD));
      reset = 1; fetch_req = 0;
      @(negedge clk);
      reset = 0;
      check("midrst_busy", 32'(busy), 32'h0);
      check("midrst_cmd", 32'(mem_cmd), 32'(MNONE));
      check("midrst_pc", 32'(pc_out), 32'h0);
      check("midrst_ir", 32'(ir_out), 32'h0);
      check("midrst_rdata", 32'(rdata_out), 32'h0);
      check("midrst_no_done", {fetch_done, ls_done}, 32'h0);
      @(negedge clk);
      check("midrst_no_late_done", {fetch_done, ls_done}, 32'h0);
      do_op(vecs[0], 100);

      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
